// File: rtl/regfile_write_arbiter.sv
// Purpose: arbitrates pipeline writeback (A) and multdiv completion (B) onto one register-file write port, and tracks registers with pending long-latency writes.
// Latency: grant is combinational; the accepted write appears on wr_* one cycle after the transfer edge.
// Backpressure: a_ready/b_ready equal the grant; at most one requester transfers per cycle and the loser simply holds its request.
//
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin contention handling;
// the default build gives A fixed priority with a 2-bit starvation counter for B.
//
// Ports:
//   clock, ctrl_reset                 posedge clock, asynchronous active-high reset
//   a_valid/a_reg/a_data -> a_ready   requester A (pipeline writeback)
//   b_valid/b_reg/b_data -> b_ready   requester B (multdiv completion), clears busy on transfer
//   issue_valid/issue_reg             long-latency issue, marks destination busy
//   rd_regA/rd_regB -> stall          source-operand hazard against pending long-latency writes
//   wr_en/wr_reg/wr_data              register-file write port (sampled by the register file on negedge)
module regfile_write_arbiter (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        a_valid,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_reg,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_reg,
    input  logic [4:0]  rd_regA,
    input  logic [4:0]  rd_regB,
    output logic        stall,
    output logic        wr_en,
    output logic [4:0]  wr_reg,
    output logic [31:0] wr_data
);

    logic        grantA;
    logic        grantB;
    logic [31:0] busy;
    logic [31:0] busyNext;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when A transferred last, so B wins the next contended cycle.
    logic        preferB;
`else
    // Cycles B has been valid and refused; saturates at 3, which flips the next contention to B.
    logic [1:0]  starveCnt;
`endif

    // Grant logic. Readies are held low throughout reset so nothing is
    // accepted that the reset would then discard.
    always_comb begin
        grantA = 1'b0;
        grantB = 1'b0;
        if (!ctrl_reset) begin
            if (a_valid && b_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
                grantB = preferB;
`else
                grantB = (starveCnt == 2'd3);
`endif
                grantA = !grantB;
            end else begin
                grantA = a_valid;
                grantB = b_valid;
            end
        end
    end

    assign a_ready = grantA;
    assign b_ready = grantB;

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            preferB <= 1'b0;
        end else if (grantA) begin
            preferB <= 1'b1;
        end else if (grantB) begin
            preferB <= 1'b0;
        end
    end
`else
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            starveCnt <= 2'd0;
        end else if (!b_valid || grantB) begin
            starveCnt <= 2'd0;
        end else if (starveCnt != 2'd3) begin
            starveCnt <= starveCnt + 2'd1;
        end
    end
`endif

    // Write port register. A write to register 0 is accepted but never
    // enabled; the fields are still captured like any granted request.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            wr_en   <= 1'b0;
            wr_reg  <= 5'd0;
            wr_data <= 32'd0;
        end else if (grantA) begin
            wr_en   <= (a_reg != 5'd0);
            wr_reg  <= a_reg;
            wr_data <= a_data;
        end else if (grantB) begin
            wr_en   <= (b_reg != 5'd0);
            wr_reg  <= b_reg;
            wr_data <= b_data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Busy scoreboard. The set is applied after the clear so a new issue to
    // the register B is retiring in the same cycle keeps it busy.
    always_comb begin
        busyNext = busy;
        if (grantB) begin
            busyNext[b_reg] = 1'b0;
        end
        if (issue_valid && (issue_reg != 5'd0)) begin
            busyNext[issue_reg] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            busy <= 32'd0;
        end else begin
            busy <= busyNext;
        end
    end

    // No bypass: the register stays busy until the edge where B transfers.
    assign stall = busy[rd_regA] | busy[rd_regB];

endmodule
